// File: rtl/ex_mem_pkg.sv
// Shared EX/MEM definitions: bundle layout, result-source encodings and store byte-enables.
package ex_mem_pkg;

    localparam int XLEN = 32;
    localparam int PC_W = 17;
    localparam int RD_W = 5;

    typedef enum logic [1:0] {
        RES_ALU     = 2'd0,
        RES_MEM     = 2'd1,
        RES_PC_PLUS = 2'd2
    } result_src_e;

    localparam logic [3:0] MW_NONE = 4'b0000;
    localparam logic [3:0] MW_BYTE = 4'b0001;
    localparam logic [3:0] MW_HALF = 4'b0011;
    localparam logic [3:0] MW_WORD = 4'b1111;

    typedef struct packed {
        logic            reg_write;
        result_src_e     result_src;
        logic [3:0]      mem_write;
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [RD_W-1:0] rd;
        logic [PC_W-1:0] pc_plus;
        logic [PC_W-1:0] pc_target;
        logic [1:0]      target_choose;
    } ex_mem_bundle_t;

    localparam int EX_MEM_W = $bits(ex_mem_bundle_t);

    // Bit offsets of each field inside the packed bundle (LSB first).
    localparam int OFS_TARGET_CHOOSE = 0;
    localparam int OFS_PC_TARGET     = OFS_TARGET_CHOOSE + 2;
    localparam int OFS_PC_PLUS       = OFS_PC_TARGET + PC_W;
    localparam int OFS_RD            = OFS_PC_PLUS + PC_W;
    localparam int OFS_WRITE_DATA    = OFS_RD + RD_W;
    localparam int OFS_ALU_RESULT    = OFS_WRITE_DATA + XLEN;
    localparam int OFS_MEM_WRITE     = OFS_ALU_RESULT + XLEN;
    localparam int OFS_RESULT_SRC    = OFS_MEM_WRITE + 4;
    localparam int OFS_REG_WRITE     = OFS_RESULT_SRC + 2;

endpackage

// File: rtl/ex_mem_pipe_stage_skid_buffer.sv
// Generic valid/ready register with an optional second (skid) entry so in_ready is a flop output.
module skid_buffer #(
    parameter int W             = 112,
    parameter bit SKID_EN       = 1'b1,
    parameter bit CLEAR_ON_KILL = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         kill_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         skid_valid_o
);

    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept, rel;

    assign in_ready_o   = SKID_EN ? !skid_valid_q : (!main_valid_q || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign rel          = main_valid_q && out_ready_i;
    assign out_valid_o  = main_valid_q;
    assign out_data_o   = main_q;
    assign skid_valid_o = skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (kill_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_KILL) begin
                main_d = '0;
                skid_d = '0;
            end
        end else if (!SKID_EN || !skid_valid_q) begin
            if (accept) begin
                // Main still occupied and not draining: park the new beat behind it.
                if (SKID_EN && main_valid_q && !rel) begin
                    skid_d       = in_data_i;
                    skid_valid_d = 1'b1;
                end else begin
                    main_d       = in_data_i;
                    main_valid_d = 1'b1;
                end
            end else if (rel) begin
                main_valid_d = 1'b0;
            end
        end else if (rel) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// Elastic EX->MEM stage: skid-buffered payload, flush kill, occupancy and a saturating stall counter.
module ex_mem_pipe_stage
    import ex_mem_pkg::*;
#(
    parameter int PAYLOAD_W      = EX_MEM_W,
    parameter bit SKID_EN        = 1'b1,
    parameter bit CLEAR_ON_FLUSH = 1'b0,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     bp_cycles,
    input  logic                 bp_clear
);

    logic             skid_valid;
    logic [CNT_W-1:0] bp_q, bp_d;

    skid_buffer #(
        .W             (PAYLOAD_W),
        .SKID_EN       (SKID_EN),
        .CLEAR_ON_KILL (CLEAR_ON_FLUSH)
    ) u_skid (
        .clk          (clk),
        .reset        (reset),
        .kill_i       (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_payload),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_payload),
        .skid_valid_o (skid_valid)
    );

    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};
    assign bp_cycles = bp_q;

    // Stall counter saturates rather than wrapping; flush deliberately leaves it alone.
    always_comb begin
        bp_d = bp_q;
        if (bp_clear) begin
            bp_d = '0;
        end else if (out_valid && !out_ready && (bp_q != {CNT_W{1'b1}})) begin
            bp_d = bp_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bp_q <= '0;
        end else begin
            bp_q <= bp_d;
        end
    end

endmodule

// File: doc/ex_mem_pipe_stage.md
Name: ex_mem_pipe_stage

Overview:
- Parametrised, elastic execute→memory pipeline stage; successor to the fixed-field EX/MEM register.
- Carries an opaque payload bundle under a valid/ready handshake. Replaces the bare stall hold with a 2-entry skid buffer so `in_ready` is fully registered.
- Adds a synchronous flush (branch/exception kill), an occupancy output and a saturating back-pressure counter.
- Sits between the ALU stage and the data-memory stage; instantiated once per issue lane.

Parameters:
- PAYLOAD_W, 112, width of the packed control+data bundle (reg_write, result_src, mem_write, alu_result, write_data, rd, pc_plus, pc_target, target_choose).
- SKID_EN, 1, 1 = 2-entry skid buffer (registered `in_ready`); 0 = single entry, `in_ready` = !main_valid | out_ready (combinational).
- CLEAR_ON_FLUSH, 0, 1 = zero the payload registers on flush; 0 = payload held, only the valid bits cleared.
- CNT_W, 16, width of the back-pressure counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  in  1  upstream (execute) has a beat
- in_ready  out  1  stage can accept a beat this cycle
- in_payload  in  PAYLOAD_W  execute-stage bundle
- flush  in  1  kill all held beats and the incoming beat
- out_valid  out  1  beat presented to the memory stage
- out_ready  in  1  memory stage accepts; logical inverse of the legacy StallM
- out_payload  out  PAYLOAD_W  bundle to the memory stage
- occupancy  out  2  number of held beats, 0..2
- bp_cycles  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0
- bp_clear  in  1  synchronous clear of bp_cycles

Behaviour:
- Reset (clk edge with reset=1):
  - main_valid=0, skid_valid=0, out_payload=0, skid payload=0, occupancy=0, bp_cycles=0.
  - Handshakes in that cycle are ignored.
  - in_ready=1 from the first cycle after reset deasserts.
- Handshake:
  - Accept = in_valid & in_ready.
  - Release = out_valid & out_ready.
  - out_valid = main_valid. out_payload comes only from the main register, never combinationally from in_payload.
  - Latency is 1 cycle when the stage is empty or flowing.
- State (SKID_EN=1), encoded by {skid_valid, main_valid}:
  - EMPTY (00): accept → FULL1, payload to main.
  - FULL1 (01):
    - accept & release → FULL1, main loads the input.
    - release only → EMPTY.
    - accept only → FULL2, input to skid.
    - neither → hold.
  - FULL2 (11): in_ready=0.
    - release → FULL1, main loads skid, skid_valid=0.
    - no release → hold.
    - The beat order main→skid is preserved; no beat is ever dropped or duplicated.
- in_ready = !skid_valid; this is a flop output with no combinational path from out_ready.
- SKID_EN=0: no skid register. in_ready = !main_valid | out_ready. FULL2 is unreachable.
- Flush:
  - Priority over accept and release.
  - Next cycle: main_valid=0, skid_valid=0; the incoming beat is dropped, even if in_ready=1.
  - A release occurring in the flush cycle still completes on the downstream side (the sink saw valid & ready); the stage does not replay it.
  - Payload is zeroed only if CLEAR_ON_FLUSH=1.
- Reset overrides flush. A reset in FULL2 discards both beats.
- occupancy = main_valid + skid_valid, registered alongside the valid bits.
- bp_cycles:
  - Increments each cycle with out_valid & !out_ready, saturating at 2^CNT_W−1 (no wrap).
  - bp_clear has priority over the increment; reset has priority over bp_clear.
  - flush does not clear bp_cycles.
- Payload registers load only on accept; there is no enable toggling when idle.

Decomposition:
- Shared package `ex_mem_pkg`:
  - Packed struct of the EX/MEM bundle with field offsets.
  - PAYLOAD_W derived from the struct.
  - result_src encodings (ALU=0, MEM=1, PC_PLUS=2).
  - mem_write byte-enable constants.
- One natural sub-module, `skid_buffer`:
  - Generic valid/ready 2-entry register holding the payload.
  - Its parent adds flush, the counter and occupancy.

Test Plan:
- Reset, then in_valid=1 with payload 0x...A5 and out_ready=1 → out_valid=1 next cycle with payload 0x...A5; occupancy=1; in_ready stays 1 throughout.
- Stream 4 beats (1,2,3,4) with out_ready=0 for cycles 2–3:
  - Occupancy reaches 2 and in_ready=0 the cycle after FULL2.
  - Output order is 1,2,3,4 with no loss.
  - bp_cycles=2.
- FULL2 holding beats 7,8, then flush=1 with in_valid=1 (beat 9) → next cycle out_valid=0, occupancy=0, in_ready=1; beat 9 never appears. With CLEAR_ON_FLUSH=1, out_payload=0.
- CNT_W=4, out_ready=0 for 20 cycles with a held beat:
  - bp_cycles saturates at 15.
  - bp_clear=1 together with stall → 0 next cycle, then increments to 1.
- Assert reset mid-stream in FULL2 → next cycle all outputs are 0 and the held beats are discarded; after reset deasserts, a new beat passes with 1-cycle latency.
- SKID_EN=0, out_ready toggling 1,0,1 with continuous in_valid → in_ready tracks out_ready combinationally while full; the output sequence matches the input sequence.
